alu_sequencer: RTL

Multicycle control unit that drives the 16-bit ALU (opcodes 0–10) and owns the program counter for the small 16-bit processor. It fetches instructions over a request/acknowledge port and decodes them into ALU opcode, immediate and register-file addresses. It sequences the ALU's one-cycle registered latency, issues the register write-back, and resolves jumps (opcodes 11, 12) and illegal opcodes (13–15) itself.

---
 rtl/cpu_pkg.sv | 59 +++++
 rtl/alu_sequencer_if.sv | 31 +++
 rtl/alu_sequencer_instr_decoder.sv | 39 +++
 rtl/alu_sequencer.sv | 78 +++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit processor control path: opcodes,
// instruction field positions, sequencer states and the decoded-instruction bundle.
package cpu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_MOV  = 4'd5;
  localparam logic [3:0] OP_ANDI = 4'd6;
  localparam logic [3:0] OP_ORI  = 4'd7;
  localparam logic [3:0] OP_XORI = 4'd8;
  localparam logic [3:0] OP_ADDI = 4'd9;
  localparam logic [3:0] OP_SUBI = 4'd10;
  localparam logic [3:0] OP_JMP  = 4'd11;
  localparam logic [3:0] OP_BEZ  = 4'd12;
  localparam logic [3:0] OP_NOP  = 4'd15;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 8;
  localparam int RS1_HI = 7;
  localparam int RS1_LO = 4;
  localparam int RS2_HI = 3;
  localparam int RS2_LO = 0;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;
  localparam int TGT_HI = 11;
  localparam int TGT_LO = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_WB,
    ST_HALT
  } state_t;

  typedef struct packed {
    logic [3:0]  codop;
    logic [15:0] imm;
    logic [3:0]  ra1;
    logic [3:0]  ra2;
    logic [3:0]  wa;
    logic        is_alu;
    logic        is_jmp;
    logic        is_bez;
    logic        illegal;
  } decode_t;

  // Only the arithmetic ops produce meaningful status; logic ops leave flags alone.
  function automatic logic sets_flags(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADDI) || (op == OP_SUBI);
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Bundles the sequencer's instruction-memory, ALU and register-file connections.
interface alu_sequencer_if #(
  parameter int PC_W = 16
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [15:0]     imem_data;
  logic [3:0]      alu_codop;
  logic [15:0]     alu_imm;
  logic [15:0]     alu_result;
  logic            alu_neg;
  logic            alu_overflow;
  logic [3:0]      rf_ra1;
  logic [3:0]      rf_ra2;
  logic [15:0]     rf_rd1;
  logic [15:0]     rf_rd2;
  logic            rf_we;
  logic [3:0]      rf_wa;
  logic [15:0]     rf_wd;

  modport master (
    output imem_req, imem_addr, alu_codop, alu_imm, rf_ra1, rf_ra2, rf_we, rf_wa, rf_wd,
    input  imem_ack, imem_data, alu_result, alu_neg, alu_overflow, rf_rd1, rf_rd2
  );

  modport slave (
    input  imem_req, imem_addr, alu_codop, alu_imm, rf_ra1, rf_ra2, rf_we, rf_wa, rf_wd,
    output imem_ack, imem_data, alu_result, alu_neg, alu_overflow, rf_rd1, rf_rd2
  );
endinterface

// File: rtl/alu_sequencer_instr_decoder.sv
// Combinational instruction decoder: splits an instruction word into ALU
// controls, register addresses and instruction-class flags.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [15:0] ir,
  output decode_t     dec
);
  logic [3:0] op;

  always_comb begin
    // NOTE: every output gets a default before the branches, so no path leaves one unassigned and no latch is inferred.
    op          = ir[OP_HI:OP_LO];
    dec         = '0;
    dec.codop   = OP_NOP;
    dec.wa      = ir[RD_HI:RD_LO];

    if (op <= OP_MOV) begin
      dec.is_alu = 1'b1;
      dec.codop  = op;
      dec.ra1    = ir[RS1_HI:RS1_LO];
      dec.ra2    = ir[RS2_HI:RS2_LO];
    end else if (op <= OP_SUBI) begin
      // Immediate forms operate in place on rd.
      dec.is_alu = 1'b1;
      dec.codop  = op;
      dec.ra2    = ir[RD_HI:RD_LO];
      dec.imm    = {{8{ir[IMM_HI]}}, ir[IMM_HI:IMM_LO]};
    end else if (op == OP_JMP) begin
      dec.is_jmp = 1'b1;
    end else if (op == OP_BEZ) begin
      dec.is_bez = 1'b1;
      dec.ra1    = ir[RS1_HI:RS1_LO];
      dec.ra2    = ir[RS2_HI:RS2_LO];
    end else begin
      dec.illegal = 1'b1;
    end
  end
endmodule

// File: rtl/alu_sequencer.sv
// Multicycle control unit: fetches, decodes and sequences each instruction
// through the registered ALU, owns the PC and status flags, traps illegal ops.
module alu_sequencer
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  alu_sequencer_if.master bus,
  output logic [PC_W-1:0] pc,
  output logic [2:0]      flags,
  output logic            halted
);
  state_t          state;
  state_t          state_nxt;
  logic [15:0]     ir;
  decode_t         dec;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] jmp_target;

  instr_decoder u_decoder (
    .ir  (ir),
    .dec (dec)
  );

  assign pc_inc     = pc + PC_W'(1);
  assign jmp_target = PC_W'(ir[TGT_HI:TGT_LO]);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (run) state_nxt = ST_FETCH;
      ST_FETCH:  if (bus.imem_ack) state_nxt = ST_DECODE;
      ST_DECODE: state_nxt = dec.illegal ? ST_HALT : ST_EXEC;
      ST_EXEC:   state_nxt = dec.is_alu ? ST_WB : ST_FETCH;
      ST_WB:     state_nxt = run ? ST_FETCH : ST_IDLE;
      ST_HALT:   state_nxt = ST_HALT;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      pc    <= RESET_PC;
      ir    <= '0;
      flags <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_FETCH && bus.imem_ack) ir <= bus.imem_data;
      if (state == ST_EXEC) begin
        if (dec.is_jmp)      pc <= jmp_target;
        else if (dec.is_bez) pc <= (bus.rf_rd1 == '0) ? PC_W'(bus.rf_rd2) : pc_inc;
      end
      if (state == ST_WB) begin
        pc <= pc_inc;
        if (sets_flags(ir[OP_HI:OP_LO]))
          flags <= {bus.alu_neg, bus.alu_result == '0, bus.alu_overflow};
      end
    end
  end

  // Outputs decode from state so an asynchronous reset drops req/we at once.
  assign bus.imem_req  = (state == ST_FETCH);
  assign bus.imem_addr = pc;
  assign bus.alu_codop = (state == ST_EXEC) ? dec.codop : OP_NOP;
  assign bus.alu_imm   = dec.imm;
  assign bus.rf_ra1    = dec.ra1;
  assign bus.rf_ra2    = dec.ra2;
  assign bus.rf_we     = (state == ST_WB);
  assign bus.rf_wa     = dec.wa;
  assign bus.rf_wd     = bus.alu_result;
  assign halted        = (state == ST_HALT);
endmodule
